// File: rtl/seven_segment_pkg.sv
// Shared constants and types for the seven-segment scan receive path.
// Segment patterns are active-high, bit0=a ... bit6=g.
package seven_segment_pkg;

  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned SEG_W   = 7;

  localparam logic [SEG_W-1:0] SEG_0 = 7'h3F;
  localparam logic [SEG_W-1:0] SEG_1 = 7'h06;
  localparam logic [SEG_W-1:0] SEG_2 = 7'h5B;
  localparam logic [SEG_W-1:0] SEG_3 = 7'h4F;
  localparam logic [SEG_W-1:0] SEG_4 = 7'h66;
  localparam logic [SEG_W-1:0] SEG_5 = 7'h6D;
  localparam logic [SEG_W-1:0] SEG_6 = 7'h7D;
  localparam logic [SEG_W-1:0] SEG_7 = 7'h07;
  localparam logic [SEG_W-1:0] SEG_8 = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_9 = 7'h6F;

  localparam logic [DIGIT_W-1:0] SEG_INVALID_BCD = 4'hF;

  typedef struct packed {
    logic               valid;
    logic [DIGIT_W-1:0] bcd;
  } digit_dec_t;

  typedef enum logic [1:0] {
    AnBlank,
    AnSingle,
    AnMulti
  } anode_class_t;

endpackage

// File: rtl/seven_segment_pattern_decoder.sv
// Combinational seven-segment pattern to BCD decoder.
// Unknown patterns report valid=0 and the invalid BCD code.
module seven_segment_pattern_decoder
  import seven_segment_pkg::*;
(
  input  logic [SEG_W-1:0] pattern_i,
  output digit_dec_t       dec_o
);

  always_comb begin
    dec_o = '{valid: 1'b1, bcd: SEG_INVALID_BCD};
    case (pattern_i)
      SEG_0:   dec_o.bcd = 4'd0;
      SEG_1:   dec_o.bcd = 4'd1;
      SEG_2:   dec_o.bcd = 4'd2;
      SEG_3:   dec_o.bcd = 4'd3;
      SEG_4:   dec_o.bcd = 4'd4;
      SEG_5:   dec_o.bcd = 4'd5;
      SEG_6:   dec_o.bcd = 4'd6;
      SEG_7:   dec_o.bcd = 4'd7;
      SEG_8:   dec_o.bcd = 4'd8;
      SEG_9:   dec_o.bcd = 4'd9;
      default: dec_o = '{valid: 1'b0, bcd: SEG_INVALID_BCD};
    endcase
  end

endmodule

// File: rtl/seven_segment_scan_decoder.sv
// Receive side of a multiplexed seven-segment bus: settles each scanned digit,
// decodes it back to BCD and publishes complete multi-digit frames.
module seven_segment_scan_decoder
  import seven_segment_pkg::*;
#(
  parameter int unsigned SEGMENT_NUM   = 4,
  parameter bit          ACTIVE_LOW    = 1'b1,
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned STALL_CYCLES  = 50000
) (
  input  logic                           i_Clk,
  input  logic                           i_Reset,
  input  logic [SEG_W-1:0]               i_Segments,
  input  logic [SEGMENT_NUM-1:0]         i_Anodes,
  output logic [DIGIT_W*SEGMENT_NUM-1:0] o_BCD_Num,
  output logic                           o_Frame_Valid,
  output logic                           o_Frame_Error,
  output logic                           o_Scan_Error,
  output logic                           o_Stalled
);

  localparam int unsigned IdxW    = (SEGMENT_NUM > 1) ? $clog2(SEGMENT_NUM) : 1;
  localparam int unsigned CntW    = $clog2(SEGMENT_NUM + 1);
  localparam int unsigned SettleW = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned StallW  = $clog2(STALL_CYCLES + 1);
  localparam int unsigned SampleW = SEGMENT_NUM + SEG_W;
  localparam int unsigned FrameW  = DIGIT_W * SEGMENT_NUM;

  localparam logic [SettleW-1:0] SettleLast = SettleW'(SETTLE_CYCLES - 1);
  localparam logic [SettleW-1:0] SettleDone = SettleW'(SETTLE_CYCLES);
  localparam logic [StallW-1:0]  StallMax   = StallW'(STALL_CYCLES);

  // Input stage, normalised to active-high.
  logic [SEG_W-1:0]       seg_d, seg_q;
  logic [SEGMENT_NUM-1:0] an_d, an_q;
  logic [SampleW-1:0]     sample, prev_q;

  assign seg_d  = ACTIVE_LOW ? ~i_Segments : i_Segments;
  assign an_d   = ACTIVE_LOW ? ~i_Anodes : i_Anodes;
  assign sample = {an_q, seg_q};

  // Anode classification of the registered sample.
  logic [CntW-1:0] active_cnt;
  logic [IdxW-1:0] digit_idx;
  anode_class_t    an_class;

  always_comb begin
    active_cnt = '0;
    digit_idx  = '0;
    for (int i = 0; i < SEGMENT_NUM; i++) begin
      if (an_q[i]) begin
        active_cnt = active_cnt + CntW'(1);
        digit_idx  = IdxW'(i);
      end
    end
    if (active_cnt == '0) begin
      an_class = AnBlank;
    end else if (active_cnt == CntW'(1)) begin
      an_class = AnSingle;
    end else begin
      an_class = AnMulti;
    end
  end

  // Settle counter parks at SettleDone after capturing so a long dwell captures once.
  logic [SettleW-1:0] settle_d, settle_q;
  logic               capture;

  always_comb begin
    settle_d = '0;
    capture  = 1'b0;
    if (an_class == AnSingle && sample == prev_q) begin
      if (settle_q == SettleLast) begin
        capture  = 1'b1;
        settle_d = SettleDone;
      end else if (settle_q == SettleDone) begin
        settle_d = SettleDone;
      end else begin
        settle_d = settle_q + SettleW'(1);
      end
    end
  end

  digit_dec_t dec;

  seven_segment_pattern_decoder u_pattern_decoder (
    .pattern_i (seg_q),
    .dec_o     (dec)
  );

  // Frame assembly. Completion clears the mask before a coincident capture sets its bit.
  logic [SEGMENT_NUM-1:0] mask_d, mask_q;
  logic [FrameW-1:0]      shadow_d, shadow_q;
  logic [FrameW-1:0]      bcd_d, bcd_q;
  logic                   err_d, err_q;
  logic                   frame_err_d, frame_err_q;
  logic                   frame_done;
  logic                   frame_valid_q;
  logic                   scan_err_q;

  always_comb begin
    frame_done  = &mask_q;
    mask_d      = frame_done ? '0 : mask_q;
    err_d       = frame_done ? 1'b0 : err_q;
    shadow_d    = shadow_q;
    bcd_d       = frame_done ? shadow_q : bcd_q;
    frame_err_d = frame_done ? err_q : frame_err_q;
    if (capture) begin
      mask_d[digit_idx]                          = 1'b1;
      shadow_d[DIGIT_W*digit_idx +: DIGIT_W]     = dec.bcd;
      err_d                                      = err_d | ~dec.valid;
    end
  end

  logic [StallW-1:0] stall_d, stall_q;

  always_comb begin
    if (capture) begin
      stall_d = '0;
    end else if (stall_q == StallMax) begin
      stall_d = stall_q;
    end else begin
      stall_d = stall_q + StallW'(1);
    end
  end

  always_ff @(posedge i_Clk or negedge i_Reset) begin
    if (!i_Reset) begin
      seg_q         <= '0;
      an_q          <= '0;
      prev_q        <= '0;
      settle_q      <= '0;
      mask_q        <= '0;
      shadow_q      <= '0;
      err_q         <= 1'b0;
      bcd_q         <= '0;
      frame_err_q   <= 1'b0;
      frame_valid_q <= 1'b0;
      scan_err_q    <= 1'b0;
      stall_q       <= '0;
    end else begin
      seg_q         <= seg_d;
      an_q          <= an_d;
      prev_q        <= sample;
      settle_q      <= settle_d;
      mask_q        <= mask_d;
      shadow_q      <= shadow_d;
      err_q         <= err_d;
      bcd_q         <= bcd_d;
      frame_err_q   <= frame_err_d;
      frame_valid_q <= frame_done;
      scan_err_q    <= (an_class == AnMulti);
      stall_q       <= stall_d;
    end
  end

  assign o_BCD_Num     = bcd_q;
  assign o_Frame_Valid = frame_valid_q;
  assign o_Frame_Error = frame_err_q;
  assign o_Scan_Error  = scan_err_q;
  assign o_Stalled     = (stall_q == StallMax);

endmodule
